dm_line_mem_resp: RTL

DM_LINE_MEM_RESP -- requirements
Module: dm_line_mem_resp

---
 rtl/dm_line_mem_resp.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dm_line_mem_resp.sv
// Line-granular memory responder with a fixed request-to-response latency.
// Optional per-type completion counters enabled by defining DM_LINE_MEM_STATS_EN.
module dm_line_mem_resp #(
  parameter int unsigned CPU_BUS_SZ   = 32,
  parameter int unsigned MEM_BUS_SZ   = 512,
  parameter int unsigned MEM_LINES    = 64,
  parameter int unsigned LATENCY      = 4,
  parameter int unsigned S_AXI_ID_SZ  = 11,
  parameter int unsigned S_AXI_LEN_SZ = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CPU_BUS_SZ-1:0]   mem_req_addr,
  input  logic [MEM_BUS_SZ-1:0]   mem_req_data,
  input  logic                    mem_req_rw,
  input  logic                    mem_req_valid,
  input  logic [S_AXI_ID_SZ-1:0]  mem_req_id,
  input  logic [S_AXI_LEN_SZ-1:0] mem_req_len,
  output logic [MEM_BUS_SZ-1:0]   mem_data_data,
  output logic                    mem_data_ready,
  output logic [S_AXI_ID_SZ-1:0]  resp_id,
  output logic                    busy,
  output logic                    req_drop,
  output logic [31:0]             rd_cnt,
  output logic [31:0]             wr_cnt
);

  localparam int unsigned LB = $clog2(MEM_BUS_SZ / 8);
  localparam int unsigned IW = $clog2(MEM_LINES);
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);
  localparam bit LAT1 = (LATENCY == 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [MEM_BUS_SZ-1:0]   data_q, data_d;
  logic                    rw_q, rw_d;
  logic [S_AXI_ID_SZ-1:0]  id_q, id_d;
  logic [S_AXI_LEN_SZ-1:0] len_q, len_d;
  logic                    accept;

  logic [MEM_BUS_SZ-1:0]   mem_q [MEM_LINES];
  logic [MEM_BUS_SZ-1:0]   rd_line;

  logic [MEM_BUS_SZ-1:0]   rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic [S_AXI_ID_SZ-1:0]  rid_q, rid_d;
  logic                    busy_q, busy_d;
  logic                    drop_q, drop_d;

  // Length and the address bits outside the line index are captured but never interpreted.
  logic unused_bits;
  assign unused_bits = ^{mem_req_addr, len_q};

  assign accept = mem_req_valid && ((state_q == IDLE) || (state_q == RESP));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (mem_req_valid) begin
          state_d = LAT1 ? RESP : WAIT;
          cnt_d   = CNT_LOAD;
        end else if (state_q == RESP) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture
  always_comb begin
    idx_d  = idx_q;
    data_d = data_q;
    rw_d   = rw_q;
    id_d   = id_q;
    len_d  = len_q;
    if (accept) begin
      idx_d  = mem_req_addr[LB+IW-1:LB];
      data_d = mem_req_data;
      rw_d   = mem_req_rw;
      id_d   = mem_req_id;
      len_d  = mem_req_len;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      data_q <= '0;
      rw_q   <= 1'b0;
      id_q   <= '0;
      len_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      data_q <= data_d;
      rw_q   <= rw_d;
      id_q   <= id_d;
      len_q  <= len_d;
    end
  end

  // A write commits at the same edge a back-to-back read loads its data, so bypass it.
  always_comb begin
    rd_line = mem_q[idx_d];
    if ((state_q == RESP) && rw_q && (idx_q == idx_d)) rd_line = data_q;
  end

  // Output logic
  always_comb begin
    rdata_d = rdata_q;
    rid_d   = rid_q;
    ready_d = (state_d == RESP);
    busy_d  = (state_d != IDLE);
    drop_d  = mem_req_valid && (state_q == WAIT);
    if (state_d == RESP) begin
      rdata_d = rw_d ? data_d : rd_line;
      rid_d   = id_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      rid_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rid_q   <= rid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  // Line store, committed at the end of a write's RESP cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(MEM_LINES); i++) mem_q[i] <= '0;
    end else if ((state_q == RESP) && rw_q) begin
      mem_q[idx_q] <= data_q;
    end
  end

  assign mem_data_data  = rdata_q;
  assign mem_data_ready = ready_q;
  assign resp_id        = rid_q;
  assign busy           = busy_q;
  assign req_drop       = drop_q;

`ifdef DM_LINE_MEM_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  // Saturating completion counters, bumped once per RESP cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (state_q == RESP) begin
      if (rw_q) begin
        if (wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_q <= wr_cnt_q + 32'd1;
      end else begin
        if (rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_q <= rd_cnt_q + 32'd1;
      end
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  assign rd_cnt = '0;
  assign wr_cnt = '0;
`endif

endmodule
